cpu_mc: RTL and testbench



---
 rtl/cpu_mc.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_mc.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK core with req/ready instruction fetch.
// Optional multiplier (opcode 0x0D) is built only when CPU_MC_MULT_EN is defined.
module cpu_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8,
  parameter int PC_WIDTH   = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  output logic                         INSTR_REQ,
  output logic [PC_WIDTH-1:0]          INSTR_ADDR,
  input  logic                         INSTR_READY,
  input  logic [31:0]                  INSTRUCTION,
  output logic                         RETIRED,
  output logic                         HALTED,
  input  logic [$clog2(REG_COUNT)-1:0] DBG_REG_SEL,
  output logic [DATA_WIDTH-1:0]        DBG_REG_DATA
);

  localparam int         IDX_W = $clog2(REG_COUNT);
  localparam logic [7:0] DW_U8 = 8'(DATA_WIDTH);

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_ROR   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_SLL   = 8'h0B;
  localparam logic [7:0] OP_SRL   = 8'h0C;
`ifdef CPU_MC_MULT_EN
  localparam logic [7:0] OP_MULT  = 8'h0D;
`endif

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t                  state_reg, state_next;
  logic                    req_reg, req_next;
  logic [31:0]             instr_reg;
  logic [PC_WIDTH-1:0]     pc_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg, result_reg;
  logic                    taken_reg;
  logic [PC_WIDTH-1:0]     target_reg;
  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];

  logic [7:0]              opcode;
  logic [7:0]              sh;
  logic [IDX_W-1:0]        dest_idx, src1_idx, src2_idx;
  logic [DATA_WIDTH-1:0]   imm_sext;
  logic                    op_legal, op_writes;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [7:0]              rot_amt;
  logic [2*DATA_WIDTH-1:0] rot_wide;
  logic                    zero_flag, branch_taken;
  logic [PC_WIDTH-1:0]     branch_target, pc_plus4;
  logic                    unused_bits;

  assign opcode        = instr_reg[31:24];
  assign sh            = instr_reg[7:0];
  assign dest_idx      = instr_reg[16 +: IDX_W];
  assign src1_idx      = instr_reg[8 +: IDX_W];
  assign src2_idx      = instr_reg[0 +: IDX_W];
  assign imm_sext      = DATA_WIDTH'($signed(instr_reg[7:0]));
  assign pc_plus4      = pc_reg + PC_WIDTH'(4);
  assign branch_target = pc_plus4 + (PC_WIDTH'($signed(instr_reg[23:16])) << 2);
  assign unused_bits   = ^instr_reg[15:8];

  always_comb begin
    op_legal  = (opcode <= OP_SRL);
    op_writes = (opcode <= OP_OR) || ((opcode >= OP_ROR) && (opcode <= OP_SRL));
`ifdef CPU_MC_MULT_EN
    if (opcode == OP_MULT) begin
      op_legal  = 1'b1;
      op_writes = 1'b1;
    end
`endif
  end

  // Shift amounts past the width saturate explicitly rather than relying on operator semantics.
  always_comb begin
    alu_result = '0;
    rot_amt    = sh % DW_U8;
    rot_wide   = {a_reg, a_reg} >> rot_amt;
    case (opcode)
      OP_LOADI: alu_result = imm_sext;
      OP_MOV:   alu_result = b_reg;
      OP_ADD:   alu_result = a_reg + b_reg;
      OP_SUB,
      OP_BEQ,
      OP_BNE:   alu_result = a_reg - b_reg;
      OP_AND:   alu_result = a_reg & b_reg;
      OP_OR:    alu_result = a_reg | b_reg;
      OP_ROR:   alu_result = rot_wide[DATA_WIDTH-1:0];
      OP_SRA:   alu_result = (sh >= DW_U8) ? {DATA_WIDTH{a_reg[DATA_WIDTH-1]}}
                                           : $unsigned($signed(a_reg) >>> sh);
      OP_SLL:   alu_result = (sh >= DW_U8) ? '0 : (a_reg << sh);
      OP_SRL:   alu_result = (sh >= DW_U8) ? '0 : (a_reg >> sh);
`ifdef CPU_MC_MULT_EN
      OP_MULT:  alu_result = a_reg * b_reg;
`endif
      default:  alu_result = '0;
    endcase
  end

  assign zero_flag = (alu_result == '0);

  always_comb begin
    branch_taken = 1'b0;
    case (opcode)
      OP_J:    branch_taken = 1'b1;
      OP_BEQ:  branch_taken = zero_flag;
      OP_BNE:  branch_taken = !zero_flag;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= S_FETCH;
      req_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
    end
  end

  // The request is registered so it rises one edge after reset releases; WRITEBACK pre-arms it
  // so a zero-wait fetch costs a single cycle.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    RETIRED    = 1'b0;
    HALTED     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (req_reg && INSTR_READY) begin
          state_next = S_DECODE;
          req_next   = 1'b0;
        end else begin
          req_next = 1'b1;
        end
      end
      S_DECODE:  state_next = op_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        RETIRED    = 1'b1;
        state_next = S_FETCH;
        req_next   = 1'b1;
      end
      S_HALT: begin
        HALTED   = 1'b1;
        req_next = 1'b0;
      end
      default: begin
        state_next = S_FETCH;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      instr_reg  <= '0;
      pc_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      taken_reg  <= 1'b0;
      target_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: if (req_reg && INSTR_READY) instr_reg <= INSTRUCTION;
        S_DECODE: begin
          a_reg <= regs[src1_idx];
          b_reg <= regs[src2_idx];
        end
        S_EXECUTE: begin
          result_reg <= alu_result;
          taken_reg  <= branch_taken;
          target_reg <= branch_target;
        end
        S_WRITEBACK: pc_reg <= taken_reg ? target_reg : pc_plus4;
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
          regs[gi] <= '0;
        else if ((state_reg == S_WRITEBACK) && op_writes && (dest_idx == IDX_W'(gi)))
          regs[gi] <= result_reg;
      end
    end
  endgenerate

  assign INSTR_REQ    = req_reg;
  assign INSTR_ADDR   = pc_reg;
  assign DBG_REG_DATA = regs[DBG_REG_SEL];

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc (DATA_WIDTH=8, REG_COUNT=8, PC_WIDTH=32).
// Instruction memory answers on the falling edge with a configurable number of wait cycles.
module tb_cpu_mc;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        INSTR_REQ;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_READY = 1'b0;
  logic [31:0] INSTRUCTION = 32'h0;
  logic        RETIRED;
  logic        HALTED;
  logic [2:0]  DBG_REG_SEL = 3'd0;
  logic [7:0]  DBG_REG_DATA;

  int checks = 0;
  int passes = 0;
  int wait_cfg = 0;
  int wait_left = 0;
  logic [31:0] imem [0:63];

  cpu_mc #(.DATA_WIDTH(8), .REG_COUNT(8), .PC_WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_REQ(INSTR_REQ), .INSTR_ADDR(INSTR_ADDR),
    .INSTR_READY(INSTR_READY), .INSTRUCTION(INSTRUCTION), .RETIRED(RETIRED),
    .HALTED(HALTED), .DBG_REG_SEL(DBG_REG_SEL), .DBG_REG_DATA(DBG_REG_DATA)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(negedge CLK);
    if (INSTR_REQ !== 1'b1) begin
      INSTR_READY = 1'b0;
      wait_left = wait_cfg;
    end else if (wait_left > 0) begin
      wait_left--;
      INSTR_READY = 1'b0;
    end else begin
      INSTR_READY = 1'b1;
      INSTRUCTION = imem[INSTR_ADDR[7:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    DBG_REG_SEL = 3'(idx);
    #1;
    v = DBG_REG_DATA;
  endtask

  // Runs until the next retirement, then one more cycle, and reports the new PC.
  task automatic step_instr(output logic [31:0] pc_next, output bit timeout);
    timeout = 1'b1;
    pc_next = 32'hxxxx_xxxx;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (RETIRED === 1'b1) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      tick();
      pc_next = INSTR_ADDR;
    end
  endtask

  task automatic test_reset();
    clear_mem();
    imem[0] = 32'h0001_0005;
    imem[1] = 32'h06FF_0000;
    wait_cfg = 0;
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (INSTR_REQ !== 1'b0) $display("FAIL reset_req: got %b want 0", INSTR_REQ); else passes++;
    checks++;
    if (INSTR_ADDR !== 32'h0) $display("FAIL reset_addr: got %h want 0", INSTR_ADDR); else passes++;
    checks++;
    if ({RETIRED, HALTED} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {RETIRED, HALTED}); else passes++;
    apply_reset();
    checks++;
    if (INSTR_REQ !== 1'b0) $display("FAIL reset_req_release: got %b want 0", INSTR_REQ); else passes++;
    tick();
    checks++;
    if (INSTR_REQ !== 1'b1) $display("FAIL reset_req_rise: got %b want 1", INSTR_REQ); else passes++;
    $display("test_reset done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_basic();
    logic [12:0] ret_mask;
    logic [7:0]  v;
    clear_mem();
    imem[0] = 32'h0001_0005;  // loadi r1,5
    imem[1] = 32'h0002_0003;  // loadi r2,3
    imem[2] = 32'h0303_0102;  // sub r3,r1,r2
    imem[3] = 32'h06FF_0000;  // j self
    wait_cfg = 0;
    apply_reset();
    for (int c = 1; c <= 13; c++) begin
      tick();
      ret_mask[c-1] = RETIRED;
    end
    checks++;
    if (ret_mask !== 13'h0888) $display("FAIL basic_retired: got %h want 0888", ret_mask); else passes++;
    checks++;
    if (INSTR_ADDR !== 32'd12) $display("FAIL basic_pc: got %0d want 12", INSTR_ADDR); else passes++;
    read_reg(1, v);
    checks++;
    if (v !== 8'h05) $display("FAIL basic_r1: got %h want 05", v); else passes++;
    read_reg(2, v);
    checks++;
    if (v !== 8'h03) $display("FAIL basic_r2: got %h want 03", v); else passes++;
    read_reg(3, v);
    checks++;
    if (v !== 8'h02) $display("FAIL basic_r3: got %h want 02", v); else passes++;
    $display("test_basic done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_wait_states();
    logic [6:0] req_mask, ret_mask;
    int         addr_bad;
    logic [7:0] v;
    clear_mem();
    imem[0] = 32'h0001_0007;  // loadi r1,7
    imem[1] = 32'h06FF_0000;
    wait_cfg = 3;
    apply_reset();
    addr_bad = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req_mask[c-1] = INSTR_REQ;
      ret_mask[c-1] = RETIRED;
      if (INSTR_REQ === 1'b1 && INSTR_ADDR !== 32'h0) addr_bad++;
    end
    checks++;
    if (req_mask !== 7'h0F) $display("FAIL wait_req: got %h want 0f", req_mask); else passes++;
    checks++;
    if (ret_mask !== 7'h40) $display("FAIL wait_retired: got %h want 40", ret_mask); else passes++;
    checks++;
    if (addr_bad !== 0) $display("FAIL wait_addr_stable: got %0d bad cycles want 0", addr_bad); else passes++;
    tick();
    read_reg(1, v);
    checks++;
    if (v !== 8'h07) $display("FAIL wait_r1: got %h want 07", v); else passes++;
    wait_cfg = 0;
    $display("test_wait_states done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_branch();
    logic [31:0] pc;
    bit          to;
    clear_mem();
    imem[0] = 32'h0601_0000;  // j +1 -> 8
    imem[2] = 32'h07FE_0101;  // beq r1,r1,-2 -> 4
    imem[1] = 32'h0810_0000;  // bne r0,r0 (equal) -> 8
    wait_cfg = 0;
    apply_reset();
    step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd8) $display("FAIL branch_j: got %0d (timeout %0d) want 8", pc, to); else passes++;
    step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd4) $display("FAIL branch_beq: got %0d (timeout %0d) want 4", pc, to); else passes++;
    step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd8) $display("FAIL branch_bne: got %0d (timeout %0d) want 8", pc, to); else passes++;
    $display("test_branch done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_shift_alu();
    logic [31:0] pc;
    bit          to;
    int          timeouts;
    logic [7:0]  v;
    logic [7:0]  exp [8];
    clear_mem();
    imem[0]  = 32'h0001_0081;  // loadi r1,0x81
    imem[1]  = 32'h0A02_0103;  // sra r2,r1,3
    imem[2]  = 32'h0C03_0109;  // srl r3,r1,9
    imem[3]  = 32'h0B04_0101;  // sll r4,r1,1
    imem[4]  = 32'h0905_0109;  // ror r5,r1,9
    imem[5]  = 32'h0006_00FF;  // loadi r6,0xFF
    imem[6]  = 32'h0007_0002;  // loadi r7,2
    imem[7]  = 32'h0206_0607;  // add r6,r6,r7
    imem[8]  = 32'h0407_0105;  // and r7,r1,r5
    imem[9]  = 32'h0500_0104;  // or r0,r1,r4
    imem[10] = 32'h06FF_0000;  // j self
    exp = '{8'h83, 8'h81, 8'hF0, 8'h00, 8'h02, 8'hC0, 8'h01, 8'h80};
    wait_cfg = 0;
    apply_reset();
    timeouts = 0;
    for (int i = 0; i < 10; i++) begin
      step_instr(pc, to);
      if (to) timeouts++;
    end
    checks++;
    if (timeouts !== 0 || pc !== 32'd40) $display("FAIL alu_pc: got %0d (timeouts %0d) want 40", pc, timeouts); else passes++;
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      checks++;
      if (v !== exp[r]) $display("FAIL alu_r%0d: got %h want %h", r, v, exp[r]); else passes++;
    end
    $display("test_shift_alu done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_halt();
    logic [31:0] pc;
    bit          to;
    int          bad;
    logic [7:0]  v;
    logic [7:0]  exp [5];
    clear_mem();
    imem[0] = 32'h0001_0009;  // loadi r1,9
    imem[1] = 32'h0102_0001;  // mov r2,r1
    imem[2] = 32'h0003_0010;  // loadi r3,0x10
    imem[3] = 32'h0004_0011;  // loadi r4,0x11
    imem[4] = 32'hFF00_0000;  // illegal
    exp = '{8'h00, 8'h09, 8'h09, 8'h10, 8'h11};
    wait_cfg = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd16) $display("FAIL halt_reach: got %0d (timeout %0d) want 16", pc, to); else passes++;
    tick();
    tick();
    checks++;
    if (HALTED !== 1'b1) $display("FAIL halt_flag: got %b want 1", HALTED); else passes++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (HALTED !== 1'b1 || INSTR_REQ !== 1'b0 || INSTR_ADDR !== 32'd16 || RETIRED !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL halt_hold: got %0d bad cycles want 0", bad); else passes++;
    for (int r = 0; r < 5; r++) begin
      read_reg(r, v);
      checks++;
      if (v !== exp[r]) $display("FAIL halt_r%0d: got %h want %h", r, v, exp[r]); else passes++;
    end
    $display("test_halt done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_mult();
    logic [31:0] pc;
    bit          to;
    logic [7:0]  v;
    clear_mem();
    imem[0] = 32'h0003_0010;  // loadi r3,0x10
    imem[1] = 32'h0004_0011;  // loadi r4,0x11
    imem[2] = 32'h0D05_0304;  // mult r5,r3,r4
    imem[3] = 32'h06FF_0000;  // j self
    wait_cfg = 0;
    apply_reset();
    step_instr(pc, to);
    step_instr(pc, to);
`ifdef CPU_MC_MULT_EN
    step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd12) $display("FAIL mult_pc: got %0d (timeout %0d) want 12", pc, to); else passes++;
    read_reg(5, v);
    checks++;
    if (v !== 8'h10) $display("FAIL mult_r5: got %h want 10", v); else passes++;
    checks++;
    if (HALTED !== 1'b0) $display("FAIL mult_halted: got %b want 0", HALTED); else passes++;
`else
    tick();
    tick();
    checks++;
    if (HALTED !== 1'b1) $display("FAIL mult_halted: got %b want 1", HALTED); else passes++;
    checks++;
    if (INSTR_ADDR !== 32'd8) $display("FAIL mult_pc: got %0d want 8", INSTR_ADDR); else passes++;
    read_reg(5, v);
    checks++;
    if (v !== 8'h00) $display("FAIL mult_r5: got %h want 00", v); else passes++;
`endif
    $display("test_mult done: checks=%0d passes=%0d", checks, passes);
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc;
    bit          to;
    logic [7:0]  v;
    clear_mem();
    imem[0] = 32'h0002_0005;  // loadi r2,5
    imem[1] = 32'h0201_0202;  // add r1,r2,r2
    imem[2] = 32'h06FF_0000;
    wait_cfg = 0;
    apply_reset();
    step_instr(pc, to);
    checks++;
    if (to || pc !== 32'd4) $display("FAIL mid_setup: got %0d (timeout %0d) want 4", pc, to); else passes++;
    tick();
    tick();
    #3 RESET = 1'b1;
    #1;
    checks++;
    if (INSTR_ADDR !== 32'd0) $display("FAIL mid_pc_async: got %0d want 0", INSTR_ADDR); else passes++;
    checks++;
    if ({INSTR_REQ, RETIRED, HALTED} !== 3'b000) $display("FAIL mid_outputs: got %b want 000", {INSTR_REQ, RETIRED, HALTED}); else passes++;
    read_reg(2, v);
    checks++;
    if (v !== 8'h00) $display("FAIL mid_r2_cleared: got %h want 00", v); else passes++;
    tick();
    tick();
    read_reg(1, v);
    checks++;
    if (v !== 8'h00) $display("FAIL mid_r1: got %h want 00", v); else passes++;
    RESET = 1'b0;
    tick();
    checks++;
    if (INSTR_REQ !== 1'b1 || INSTR_ADDR !== 32'd0) $display("FAIL mid_restart: got req=%b addr=%0d want req=1 addr=0", INSTR_REQ, INSTR_ADDR); else passes++;
    $display("test_reset_mid done: checks=%0d passes=%0d", checks, passes);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_branch();
    test_shift_alu();
    test_halt();
    test_mult();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
